// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered mux with fixed-select or round-robin grant and valid/ready on every side.
// Define MUX_ARB_LOCK_EN to add i_last and hold round-robin grants on one channel until the end of a burst.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  input  logic [SELW-1:0]    i_sel,
  input  logic [N-1:0]       i_valid,
  input  logic [N*WIDTH-1:0] i_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]       i_last,
`endif
  output logic [N-1:0]       o_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [SELW-1:0]    o_chan,
  input  logic               i_ready
);
  logic [SELW-1:0] ptr, gch, nxt;
  logic [N-1:0] grant;
  logic load, acc, last, locked;
`ifdef MUX_ARB_LOCK_EN
  localparam logic [0:0] IDLE = 1'b0, LOCKED = 1'b1;
  logic [0:0] state;
  logic [SELW-1:0] lk;
  assign locked = state == LOCKED;
  assign last = i_last[gch];
`else
  assign locked = 1'b0;
  assign last = 1'b1;
`endif
  function automatic logic [SELW-1:0] wrap(input int a);
    return SELW'(a >= N ? a - N : a);
  endfunction
  always_comb begin
    grant = '0;
    gch = '0;
    if (!i_mode) begin
      if (int'(i_sel) < N && i_valid[i_sel]) begin
        grant[i_sel] = 1'b1;
        gch = i_sel;
      end
    end else if (locked) begin
`ifdef MUX_ARB_LOCK_EN
      grant[lk] = i_valid[lk];
      gch = lk;
`endif
    end else begin
      // scan from the farthest offset down so the first requester after ptr wins
      for (int o = N - 1; o >= 0; o--) begin
        if (i_valid[wrap(int'(ptr) + o)]) begin
          grant = '0;
          grant[wrap(int'(ptr) + o)] = 1'b1;
          gch = wrap(int'(ptr) + o);
        end
      end
    end
  end
  assign load = !o_valid || i_ready;
  assign acc = load && |grant && !i_rst;
  assign nxt = (int'(gch) == N - 1) ? '0 : gch + 1'b1;
  assign o_ready = i_rst ? '0 : grant & {N{load}};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_chan <= '0;
      ptr <= '0;
`ifdef MUX_ARB_LOCK_EN
      state <= IDLE;
      lk <= '0;
`endif
    end else begin
      if (load) begin
        o_valid <= |grant;
        if (|grant) begin
          o_data <= i_data[int'(gch)*WIDTH +: WIDTH];
          o_chan <= gch;
        end
      end
      if (acc && i_mode && last) ptr <= nxt;
`ifdef MUX_ARB_LOCK_EN
      if (!i_mode) state <= IDLE;
      else if (acc) begin
        state <= last ? IDLE : LOCKED;
        lk <= gch;
      end
`endif
    end
  end
endmodule
